// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch port, the load/store port and the
// single-port memory bus that mem_arbiter sits between.
//
// Handshake rule (both request and response channels): a transfer happens
// on a rising clock edge where valid && ready are both high. A producer
// holds valid and its payload stable until that edge; ready may depend
// combinationally on valid.
//
// Modports:
//   slave  - the arbiter: takes requests and memory read data, drives
//            ready, responses and the memory control/write bus.
//   master - the core and memory side: drives requests, response ready
//            and memory read data.
interface mem_arbiter_if;
  // instruction-fetch port
  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_addr;
  logic        if_rsp_valid;
  logic        if_rsp_ready;
  logic [31:0] if_rsp_rdata;
  logic        if_rsp_err;
  // load/store port
  logic        d_req_valid;
  logic        d_req_ready;
  logic [31:0] d_addr;
  logic        d_we;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_rsp_valid;
  logic        d_rsp_ready;
  logic [31:0] d_rsp_rdata;
  logic        d_rsp_err;
  // memory bus (combinational read, synchronous write)
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_byte_en;
  logic        mem_w_en;
  logic [31:0] mem_read_data;

  modport slave (
    input  if_req_valid, if_addr, if_rsp_ready,
    input  d_req_valid, d_addr, d_we, d_wdata, d_be, d_rsp_ready,
    input  mem_read_data,
    output if_req_ready, if_rsp_valid, if_rsp_rdata, if_rsp_err,
    output d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err,
    output mem_address, mem_write_data, mem_byte_en, mem_w_en
  );

  modport master (
    output if_req_valid, if_addr, if_rsp_ready,
    output d_req_valid, d_addr, d_we, d_wdata, d_be, d_rsp_ready,
    output mem_read_data,
    input  if_req_ready, if_rsp_valid, if_rsp_rdata, if_rsp_err,
    input  d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err,
    input  mem_address, mem_write_data, mem_byte_en, mem_w_en
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one combinational-read,
// synchronous-write word memory between an instruction-fetch port and a
// load/store port. One outstanding request per port; responses are
// registered and visible the cycle after the grant. Misaligned accesses
// return err=1, rdata=0 and never assert the memory write enable.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - mem_arbiter_if.slave: fetch port, data port, memory bus
// Parameter:
//   WORDS  - depth of the attached memory (informational; addresses are
//            passed through unmasked)
module mem_arbiter #(
  parameter int WORDS = 64
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  // prio: 0 = fetch wins a tie, 1 = data wins a tie
  logic prio;

  logic if_avail;
  logic d_avail;
  logic if_elig;
  logic d_elig;
  logic grant_if;
  logic grant_d;
  logic if_mis;
  logic d_mis;

  // A port may take a new request when its response slot is empty or is
  // being drained this very cycle. Grants are gated with rst_n so that
  // nothing is accepted or written while reset is asserted.
  always_comb begin
    if_avail = !bus.if_rsp_valid || bus.if_rsp_ready;
    d_avail  = !bus.d_rsp_valid  || bus.d_rsp_ready;
    if_elig  = bus.if_req_valid && if_avail;
    d_elig   = bus.d_req_valid  && d_avail;
    grant_if = rst_n && if_elig && (!d_elig || !prio);
    grant_d  = rst_n && d_elig  && (!if_elig || prio);
    if_mis   = (bus.if_addr[1:0] != 2'b00);
    d_mis    = (bus.d_addr[1:0]  != 2'b00);
  end

  always_comb begin
    bus.if_req_ready = grant_if;
    bus.d_req_ready  = grant_d;
  end

  // Memory drive: the fetch address is presented whenever data is not
  // granted, so fetch reads need no extra muxing. Only an aligned, granted
  // store raises the write enable.
  always_comb begin
    bus.mem_address    = bus.if_addr;
    bus.mem_write_data = bus.d_wdata;
    bus.mem_byte_en    = 4'h0;
    bus.mem_w_en       = 1'b0;
    if (grant_d) begin
      bus.mem_address = bus.d_addr;
      bus.mem_byte_en = bus.d_be;
      bus.mem_w_en    = bus.d_we && !d_mis;
    end
  end

  // Priority flips to the port that lost (or was not granted).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= 1'b0;
    end else if (grant_if) begin
      prio <= 1'b1;
    end else if (grant_d) begin
      prio <= 1'b0;
    end
  end

  // Fetch response register: a grant reloads it even when the old
  // response is draining in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.if_rsp_valid <= 1'b0;
      bus.if_rsp_rdata <= 32'h0;
      bus.if_rsp_err   <= 1'b0;
    end else if (grant_if) begin
      bus.if_rsp_valid <= 1'b1;
      bus.if_rsp_rdata <= if_mis ? 32'h0 : bus.mem_read_data;
      bus.if_rsp_err   <= if_mis;
    end else if (bus.if_rsp_valid && bus.if_rsp_ready) begin
      bus.if_rsp_valid <= 1'b0;
    end
  end

  // Data response register: stores and misaligned accesses return zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.d_rsp_valid <= 1'b0;
      bus.d_rsp_rdata <= 32'h0;
      bus.d_rsp_err   <= 1'b0;
    end else if (grant_d) begin
      bus.d_rsp_valid <= 1'b1;
      bus.d_rsp_rdata <= (d_mis || bus.d_we) ? 32'h0 : bus.mem_read_data;
      bus.d_rsp_err   <= d_mis;
    end else if (bus.d_rsp_valid && bus.d_rsp_ready) begin
      bus.d_rsp_valid <= 1'b0;
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port word memory between the core's instruction-fetch port and its load/store port. It applies round-robin arbitration with valid/ready handshakes and drives the memory's combinational-read, synchronous-write interface. Responses are registered, with one outstanding request allowed per port. Misaligned accesses are rejected with an error response and never reach the memory's write enable.

## Interface
- `WORDS`, default 64: depth of the attached memory; used only by the bench. No address masking is done here.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_req_valid` in 1: fetch request present.
- `if_req_ready` out 1: fetch request accepted this cycle.
- `if_addr` in 32: fetch byte address.
- `if_rsp_valid` out 1: fetch response held.
- `if_rsp_ready` in 1: fetch consumer takes the response.
- `if_rsp_rdata` out 32: fetched word.
- `if_rsp_err` out 1: misaligned fetch.
- `d_req_valid` in 1: data request present.
- `d_req_ready` out 1: data request accepted.
- `d_addr` in 32: data byte address.
- `d_we` in 1: 1 = store, 0 = load.
- `d_wdata` in 32: store data.
- `d_be` in 4: store byte enables.
- `d_rsp_valid` out 1: data response held.
- `d_rsp_ready` in 1: consumer takes the response.
- `d_rsp_rdata` out 32: load data; 0 for stores.
- `d_rsp_err` out 1: misaligned access.
- `mem_address` out 32: to memory `address`.
- `mem_write_data` out 32: to memory `write_data`.
- `mem_byte_en` out 4: to memory `byte_en`.
- `mem_w_en` out 1: to memory `w_en`.
- `mem_read_data` in 32: from memory `read_data` (combinational).

## Operation
- **Slot availability:** per port p, `avail_p = !p_rsp_valid || p_rsp_ready`. This is one outstanding request per port, with same-cycle refill when the response is consumed.
- **Eligibility:** `elig_p = p_req_valid && avail_p`.
- **Grant:** combinational, at most one port per cycle.
  - Only one port eligible: that port wins.
  - Both eligible: the port selected by the priority register `prio` wins (0 = fetch, 1 = data).
- **Ready:** `p_req_ready = grant_p`. A handshake occurs when `valid && ready`.
- **Priority update:** after any grant, `prio` points to the non-granted port. Cycles with no grant leave `prio` unchanged.
- **Memory drive in the grant cycle:**
  - `mem_address` = granted address.
  - Data grant: `mem_write_data` = `d_wdata`, `mem_byte_en` = `d_be`.
  - `mem_w_en` = granted is data && `d_we` && `d_addr[1:0]==0`.
- **Memory drive with no grant:** `mem_address` = `if_addr`, `mem_byte_en` = 0, `mem_w_en` = 0.
- **Fetch grant never writes:** `mem_byte_en` = 0, `mem_w_en` = 0.
- **Misalignment:** `addr[1:0] != 0` on either port gives a response with `err=1` and `rdata=0`. No write occurs, regardless of `d_be`.
- **Response capture:** on the grant edge, the granted port's response register loads as follows.
  - `rsp_valid` = 1.
  - `rsp_rdata` = `mem_read_data` for aligned reads, 0 for stores or misaligned accesses.
  - `err` as defined above.
- **Response hold:** the response is held stable until `rsp_valid && rsp_ready`. It then clears unless a new grant to the same port reloads it in that same cycle.
- **Port independence:** the two response registers are independent. A stalled consumer on one port never blocks grants to the other port.

## Timing
- **Reset (asynchronous, `rst_n` = 0):**
  - `if_rsp_valid` = `d_rsp_valid` = 0.
  - `rsp_rdata` = 0, `rsp_err` = 0.
  - `prio` = 0 (fetch first).
  - `mem_w_en` = 0 and `mem_byte_en` = 0 while reset is asserted.
  - A request in flight at reset is dropped with no response. A write granted in the cycle reset asserts is not performed.
- **Latency:** request accepted at edge N gives `rsp_valid` high from just after edge N, i.e. visible in cycle N+1. Throughput is one request per cycle in total.
- **Read data:** reflects memory contents before any write at edge N. A store at edge N followed by a load granted in cycle N+1 returns the new data.
- **Back-to-back on one port:** possible every cycle while the consumer holds `rsp_ready` = 1.

## Test plan
- **Reset state:** reset, then idle → all `rsp_valid` = 0, `mem_w_en` = 0. With only fetch valid, the first grant goes to fetch.
- **Store then load:** store `d_addr` = 0x8, `d_wdata` = 0xDEADBEEF, `d_be` = 0xF, then load 0x8 → store response `err` = 0, `rdata` = 0. Load `rdata` = 0xDEADBEEF one cycle after its grant.
- **Contention:** both ports valid continuously, both `rsp_ready` = 1 → grants alternate fetch, data, fetch, data; each port gets a response every other cycle.
- **Partial store:** write 0x11223344 to 0x4, then store 0xAABBCCDD with `d_be` = 0b0010 → a read of 0x4 returns 0x1122CC44.
- **Misaligned store:** store to 0x6 with `d_be` = 0xF → `mem_w_en` never high, `d_rsp_err` = 1. A read of 0x4 is unchanged.
- **Backpressure and reset:**
  - Hold `d_rsp_ready` = 0 → `d_req_ready` stays 0 and `d_rsp_rdata` is stable, while fetch is still granted each cycle.
  - Assert `rst_n` = 0 mid-stream → `rsp_valid` drops immediately (asynchronously) and no write is issued.
